// File: rtl/me_stage.sv
// Memory-access stage: EX/ME pipeline register plus byte-addressable data
// memory with sub-word loads/stores and misalignment detection.
module me_stage #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_me,
   input  logic        flush_me,
   input  logic [31:0] PCP4_ex,
   input  logic        RUWr_ex,
   input  logic [1:0]  RUDataWrSrc_ex,
   input  logic [4:0]  RD_ex,
   input  logic [31:0] ALURes_ex,
   input  logic [31:0] RUrs2_ex,
   input  logic        DMWr_ex,
   input  logic [2:0]  DMCtrl_ex,
   output logic [31:0] PCP4_me,
   output logic        RUWr_me,
   output logic [1:0]  RUDataWrSrc_me,
   output logic [4:0]  RD_me,
   output logic [31:0] ALURes_me,
   output logic [31:0] DMDataRd_me,
   output logic        misalign_me
);

   logic [31:0] pcp4_q, pcp4_d;
   logic        ruwr_q, ruwr_d;
   logic [1:0]  src_q, src_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] alures_q, alures_d;
   logic [31:0] rs2_q, rs2_d;
   logic        dmwr_q, dmwr_d;
   logic [2:0]  ctrl_q, ctrl_d;

   logic [31:0] mem [2**ADDR_W];

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        lane;
   logic              is_byte, is_half, is_word, is_load;
   logic [31:0]       rd_word, rd_shift;
   logic [15:0]       rd_half;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic              we;

   // EX/ME next state: flush beats stall, stall holds, otherwise capture
   always_comb begin
      pcp4_d   = pcp4_q;
      ruwr_d   = ruwr_q;
      src_d    = src_q;
      rd_d     = rd_q;
      alures_d = alures_q;
      rs2_d    = rs2_q;
      dmwr_d   = dmwr_q;
      ctrl_d   = ctrl_q;
      if (flush_me) begin
         pcp4_d   = '0;
         ruwr_d   = 1'b0;
         src_d    = '0;
         rd_d     = '0;
         alures_d = '0;
         rs2_d    = '0;
         dmwr_d   = 1'b0;
         ctrl_d   = '0;
      end else if (!stall_me) begin
         pcp4_d   = PCP4_ex;
         ruwr_d   = RUWr_ex;
         src_d    = RUDataWrSrc_ex;
         rd_d     = RD_ex;
         alures_d = ALURes_ex;
         rs2_d    = RUrs2_ex;
         dmwr_d   = DMWr_ex;
         ctrl_d   = DMCtrl_ex;
      end
   end

   // EX/ME register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcp4_q   <= '0;
         ruwr_q   <= 1'b0;
         src_q    <= '0;
         rd_q     <= '0;
         alures_q <= '0;
         rs2_q    <= '0;
         dmwr_q   <= 1'b0;
         ctrl_q   <= '0;
      end else begin
         pcp4_q   <= pcp4_d;
         ruwr_q   <= ruwr_d;
         src_q    <= src_d;
         rd_q     <= rd_d;
         alures_q <= alures_d;
         rs2_q    <= rs2_d;
         dmwr_q   <= dmwr_d;
         ctrl_q   <= ctrl_d;
      end
   end

   // Access decode, misalignment, load extraction and store lane steering
   always_comb begin
      word_idx = alures_q[ADDR_W+1:2];
      lane     = alures_q[1:0];
      // 011/110/111 fall into the word case
      is_byte  = (ctrl_q[1:0] == 2'b00);
      is_half  = (ctrl_q[1:0] == 2'b01);
      is_word  = !is_byte && !is_half;
      is_load  = (src_q == 2'b01);

      misalign_me = (dmwr_q || is_load) &&
                    ((is_half && lane[0]) || (is_word && (lane != 2'b00)));

      rd_word  = mem[word_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

      DMDataRd_me = '0;
      if (is_load && !misalign_me) begin
         if (is_byte)
            DMDataRd_me = {{24{rd_shift[7] & ~ctrl_q[2]}}, rd_shift[7:0]};
         else if (is_half)
            DMDataRd_me = {{16{rd_half[15] & ~ctrl_q[2]}}, rd_half};
         else
            DMDataRd_me = rd_word;
      end

      if (is_byte) begin
         be    = 4'b0001 << lane;
         wdata = {4{rs2_q[7:0]}};
      end else if (is_half) begin
         be    = lane[1] ? 4'b1100 : 4'b0011;
         wdata = {2{rs2_q[15:0]}};
      end else begin
         be    = 4'b1111;
         wdata = rs2_q;
      end

      we = dmwr_q && !stall_me && !misalign_me && rst_n;
   end

   // Data memory byte-enable write at the edge ending the store's ME cycle
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign PCP4_me        = pcp4_q;
   assign RUWr_me        = ruwr_q;
   assign RUDataWrSrc_me = src_q;
   assign RD_me          = rd_q;
   assign ALURes_me      = alures_q;

endmodule

// File: tb/tb_me_stage.sv
// Scoreboard bench for me_stage: directed loads/stores with hand-computed
// expectations, checked by a monitor whenever a new instruction reaches ME.
module tb_me_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_me, flush_me;
   logic [31:0] PCP4_ex;
   logic        RUWr_ex;
   logic [1:0]  RUDataWrSrc_ex;
   logic [4:0]  RD_ex;
   logic [31:0] ALURes_ex, RUrs2_ex;
   logic        DMWr_ex;
   logic [2:0]  DMCtrl_ex;
   logic [31:0] PCP4_me;
   logic        RUWr_me;
   logic [1:0]  RUDataWrSrc_me;
   logic [4:0]  RD_me;
   logic [31:0] ALURes_me, DMDataRd_me;
   logic        misalign_me;

   me_stage #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .stall_me(stall_me), .flush_me(flush_me),
      .PCP4_ex(PCP4_ex), .RUWr_ex(RUWr_ex), .RUDataWrSrc_ex(RUDataWrSrc_ex),
      .RD_ex(RD_ex), .ALURes_ex(ALURes_ex), .RUrs2_ex(RUrs2_ex),
      .DMWr_ex(DMWr_ex), .DMCtrl_ex(DMCtrl_ex),
      .PCP4_me(PCP4_me), .RUWr_me(RUWr_me), .RUDataWrSrc_me(RUDataWrSrc_me),
      .RD_me(RD_me), .ALURes_me(ALURes_me), .DMDataRd_me(DMDataRd_me),
      .misalign_me(misalign_me)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        ruwr;
      logic [1:0]  src;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] pc_cnt   = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bubble_inputs();
      PCP4_ex = '0; RUWr_ex = 1'b0; RUDataWrSrc_ex = '0; RD_ex = '0;
      ALURes_ex = '0; RUrs2_ex = '0; DMWr_ex = 1'b0; DMCtrl_ex = '0;
   endtask

   task automatic issue(input logic ruwr, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic dmwr,
                        input logic [2:0] ctrl, input logic [31:0] edata, input logic emis);
      exp_t e;
      pc_cnt += 32'd4;
      PCP4_ex = pc_cnt; RUWr_ex = ruwr; RUDataWrSrc_ex = src; RD_ex = rd;
      ALURes_ex = alu; RUrs2_ex = rs2; DMWr_ex = dmwr; DMCtrl_ex = ctrl;
      e.pc = pc_cnt; e.ruwr = ruwr; e.src = src; e.rd = rd;
      e.alu = alu; e.data = edata; e.mis = emis;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic st(input logic [2:0] ctrl, input logic [31:0] addr, input logic [31:0] data,
                     input logic emis);
      issue(1'b0, 2'b00, 5'd0, addr, data, 1'b1, ctrl, 32'd0, emis);
   endtask

   task automatic ld(input logic [2:0] ctrl, input logic [4:0] rd, input logic [31:0] addr,
                     input logic [31:0] edata, input logic emis);
      issue(1'b1, 2'b01, rd, addr, 32'hFFFF_FFFF, 1'b0, ctrl, edata, emis);
   endtask

   task automatic idle(input int n);
      bubble_inputs();
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_pcp4"}, PCP4_me, 32'd0);
      chk({tag, "_ruwr"}, {31'd0, RUWr_me}, 32'd0);
      chk({tag, "_src"},  {30'd0, RUDataWrSrc_me}, 32'd0);
      chk({tag, "_rd"},   {27'd0, RD_me}, 32'd0);
      chk({tag, "_alu"},  ALURes_me, 32'd0);
      chk({tag, "_data"}, DMDataRd_me, 32'd0);
      chk({tag, "_mis"},  {31'd0, misalign_me}, 32'd0);
   endtask

   // Monitor: each new PC appearing in ME is one instruction to score
   initial begin
      logic [31:0] last_pc;
      exp_t e;
      last_pc = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && PCP4_me != 32'd0 && PCP4_me != last_pc) begin
            last_pc = PCP4_me;
            if (sb.size() == 0) begin
               chk("sb_unexpected_pc", PCP4_me, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("pcp4",  PCP4_me, e.pc);
               chk("ruwr",  {31'd0, RUWr_me}, {31'd0, e.ruwr});
               chk("src",   {30'd0, RUDataWrSrc_me}, {30'd0, e.src});
               chk("rd",    {27'd0, RD_me}, {27'd0, e.rd});
               chk("alures", ALURes_me, e.alu);
               chk("dmdata", DMDataRd_me, e.data);
               chk("misalign", {31'd0, misalign_me}, {31'd0, e.mis});
            end
         end
      end
   end

   initial begin
      int waited;
      rst_n = 1'b0; stall_me = 1'b0; flush_me = 1'b0;
      bubble_inputs();
      #2;
      chk_zero_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Clear the words used below
      st(3'b010, 32'h10, 32'h0, 1'b0);
      st(3'b010, 32'h30, 32'h0, 1'b0);
      st(3'b010, 32'h40, 32'h7777_7777, 1'b0);
      st(3'b010, 32'h60, 32'h1111_1111, 1'b0);

      // Reset mid-operation: pending store must never land
      st(3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
      bubble_inputs();
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      ld(3'b010, 5'd1, 32'h10, 32'h0000_0000, 1'b0);

      // Word round trip
      st(3'b010, 32'h20, 32'h1234_5678, 1'b0);
      ld(3'b010, 5'd2, 32'h20, 32'h1234_5678, 1'b0);
      ld(3'b000, 5'd3, 32'h23, 32'h0000_0012, 1'b0);
      ld(3'b100, 5'd4, 32'h20, 32'h0000_0078, 1'b0);
      // Non-load writeback sources read as zero
      issue(1'b1, 2'b00, 5'd5, 32'h20, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0);
      issue(1'b1, 2'b10, 5'd6, 32'h20, 32'h0, 1'b0, 3'b010, 32'h0, 1'b0);

      // Sub-word signed/unsigned, upper store-data bits must be ignored
      st(3'b000, 32'h31, 32'h1234_5680, 1'b0);
      st(3'b001, 32'h32, 32'hABCD_F00F, 1'b0);
      ld(3'b010, 5'd7, 32'h30, 32'hF00F_8000, 1'b0);
      ld(3'b001, 5'd8, 32'h32, 32'hFFFF_F00F, 1'b0);
      ld(3'b101, 5'd9, 32'h32, 32'h0000_F00F, 1'b0);
      ld(3'b000, 5'd10, 32'h31, 32'hFFFF_FF80, 1'b0);
      ld(3'b100, 5'd11, 32'h31, 32'h0000_0080, 1'b0);
      ld(3'b111, 5'd12, 32'h30, 32'hF00F_8000, 1'b0);

      // Misalignment
      st(3'b010, 32'h42, 32'hAAAA_AAAA, 1'b1);
      ld(3'b010, 5'd13, 32'h40, 32'h7777_7777, 1'b0);
      ld(3'b001, 5'd7, 32'h41, 32'h0000_0000, 1'b1);
      ld(3'b010, 5'd14, 32'h43, 32'h0000_0000, 1'b1);
      ld(3'b100, 5'd15, 32'h43, 32'h0000_0077, 1'b0);

      // Store held by stall for 3 cycles, then released
      st(3'b010, 32'h50, 32'hCAFE_F00D, 1'b0);
      bubble_inputs();
      stall_me = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("stall_hold_pc", PCP4_me, pc_cnt);
      stall_me = 1'b0;
      ld(3'b010, 5'd16, 32'h50, 32'hCAFE_F00D, 1'b0);

      // Flush with stall: held store discarded, bubble loaded
      issue(1'b1, 2'b00, 5'd17, 32'h60, 32'h9999_9999, 1'b1, 3'b010, 32'h0, 1'b0);
      bubble_inputs();
      stall_me = 1'b1; flush_me = 1'b1;
      @(posedge clk); #1;
      stall_me = 1'b0; flush_me = 1'b0;
      chk("flush_ruwr", {31'd0, RUWr_me}, 32'd0);
      chk("flush_pcp4", PCP4_me, 32'd0);
      ld(3'b010, 5'd18, 32'h60, 32'h1111_1111, 1'b0);

      // Address wrap-around
      st(3'b010, 32'h1004, 32'h0000_0055, 1'b0);
      ld(3'b010, 5'd19, 32'h0004, 32'h0000_0055, 1'b0);

      idle(2);
      waited = 0;
      while (sb.size() != 0 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
